pc_unit: RTL and testbench

- Program counter stage directly downstream of the CPU control FSM; it consumes the FSM's PC-enable pulse (PCe, issued once per instruction in the write-back state).
- Holds the current instruction address and computes the next one: sequential, conditional displacement branch (Bcond), conditional register jump (Jcond), or jump-and-link (JAL).
- Evaluates branch conditions against the processor flags.
- Drives the instruction-memory address and a link-register write for JAL.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/pc_unit_cond_eval.sv | 40 ++++
 rtl/pc_unit.sv | 107 ++++++++++
 tb/tb_pc_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: branch types, condition codes, flag bit positions, PC FSM states.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        BR_SEQ   = 2'b00,
        BR_BCOND = 2'b01,
        BR_JCOND = 2'b10,
        BR_JAL   = 2'b11
    } br_type_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_HI = 4'h4;
    localparam logic [3:0] COND_LS = 4'h5;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_LE = 4'h7;
    localparam logic [3:0] COND_FS = 4'h8;
    localparam logic [3:0] COND_FC = 4'h9;
    localparam logic [3:0] COND_LO = 4'hA;
    localparam logic [3:0] COND_HS = 4'hB;
    localparam logic [3:0] COND_LT = 4'hC;
    localparam logic [3:0] COND_GE = 4'hD;
    localparam logic [3:0] COND_UC = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Flags arrive as {N,Z,F,L,C}
    localparam int unsigned FLAG_N = 4;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_unit_cond_eval.sv
// Combinational branch-condition evaluator: condition code + flags -> condition true.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       is_true_c
);

    logic n, z, f, l, c;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign f = flags[FLAG_F];
    assign l = flags[FLAG_L];
    assign c = flags[FLAG_C];

    always_comb begin
        is_true_c = 1'b0;
        case (cond)
            COND_EQ: is_true_c = z;
            COND_NE: is_true_c = ~z;
            COND_CS: is_true_c = c;
            COND_CC: is_true_c = ~c;
            COND_HI: is_true_c = l;
            COND_LS: is_true_c = ~l;
            COND_GT: is_true_c = n;
            COND_LE: is_true_c = ~n;
            COND_FS: is_true_c = f;
            COND_FC: is_true_c = ~f;
            COND_LO: is_true_c = ~l & ~z;
            COND_HS: is_true_c = l | z;
            COND_LT: is_true_c = ~n & ~z;
            COND_GE: is_true_c = n | z;
            COND_UC: is_true_c = 1'b1;
            default: is_true_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter: sequential advance, Bcond/Jcond/JAL redirects, JAL link write.
// Optional branch-to-self halt detection enabled by defining PC_HALT_DETECT_EN.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W     = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_en,
    input  logic [1:0]        br_type,
    input  logic [3:0]        cond,
    input  logic [7:0]        disp,
    input  logic [ADDR_W-1:0] tgt_reg,
    input  logic [4:0]        flags,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data,
    output logic              taken,
    output logic              halted
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] link_data_q, link_data_d;
    logic              link_we_q, link_we_d;
    logic              taken_q, taken_d;

    logic              cond_true;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] disp_ext;

    cond_eval u_cond_eval (
        .cond      (cond),
        .flags     (flags),
        .is_true_c (cond_true)
    );

    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign disp_ext = {{(ADDR_W-8){disp[7]}}, disp};

    // Redirect decision and target for the current br_type
    always_comb begin
        redirect = 1'b0;
        target   = tgt_reg;
        case (br_type)
            BR_BCOND: begin
                redirect = cond_true;
                target   = pc_q + disp_ext;
            end
            BR_JCOND: redirect = cond_true;
            BR_JAL:   redirect = 1'b1;
            default:  redirect = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        link_data_d = link_data_q;
        link_we_d   = 1'b0;
        taken_d     = 1'b0;
        if (state_q == ST_RUN && pc_en) begin
            pc_d    = redirect ? target : pc_plus1;
            taken_d = redirect;
            if (br_type == BR_JAL) begin
                link_we_d   = 1'b1;
                link_data_d = pc_plus1;
            end
`ifdef PC_HALT_DETECT_EN
            if (redirect && target == pc_q) begin
                state_d = ST_HALT;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_ADDR;
            link_data_q <= '0;
            link_we_q   <= 1'b0;
            taken_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            link_data_q <= link_data_d;
            link_we_q   <= link_we_d;
            taken_q     <= taken_d;
        end
    end

    assign pc        = pc_q;
    assign link_we   = link_we_q;
    assign link_data = link_data_q;
    assign taken     = taken_q;
`ifdef PC_HALT_DETECT_EN
    assign halted    = (state_q == ST_HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, branches, JAL link, wrap, idle, reset abort, self-branch.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        pc_en;
    logic [1:0]  br_type;
    logic [3:0]  cond;
    logic [7:0]  disp;
    logic [15:0] tgt_reg;
    logic [4:0]  flags;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        link_we;
    logic [15:0] link_data;
    logic        taken;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    pc_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_en     (pc_en),
        .br_type   (br_type),
        .cond      (cond),
        .disp      (disp),
        .tgt_reg   (tgt_reg),
        .flags     (flags),
        .pc        (pc),
        .pc_plus1  (pc_plus1),
        .link_we   (link_we),
        .link_data (link_data),
        .taken     (taken),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One pc_en cycle: drive at negedge, sample 1 time unit after the rising edge
    task automatic step(input logic [1:0] bt, input logic [3:0] c, input logic [7:0] d,
                        input logic [15:0] t, input logic [4:0] f);
        @(negedge clk);
        pc_en = 1'b1; br_type = bt; cond = c; disp = d; tgt_reg = t; flags = f;
        @(posedge clk);
        #1;
        pc_en = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        pc_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pc_en = 1'b0; br_type = 2'b00; cond = 4'h0;
        disp = 8'h00; tgt_reg = 16'h0000; flags = 5'b00000;

        // Reset state
        @(posedge clk); #1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_link_we", {15'b0, link_we}, 16'h0000);
        chk("rst_taken", {15'b0, taken}, 16'h0000);
        chk("rst_link_data", link_data, 16'h0000);
        chk("rst_halted", {15'b0, halted}, 16'h0000);
        @(negedge clk); rst_n = 1'b1;

        // Three sequential advances
        step(2'b00, 4'h0, 8'h00, 16'h0000, 5'b00000);
        step(2'b00, 4'h0, 8'h00, 16'h0000, 5'b00000);
        step(2'b00, 4'h0, 8'h00, 16'h0000, 5'b00000);
        chk("seq_pc", pc, 16'h0003);
        chk("seq_pc_plus1", pc_plus1, 16'h0004);
        chk("seq_taken", {15'b0, taken}, 16'h0000);

        // Bcond EQ taken with negative displacement
        step(2'b10, 4'hE, 8'h00, 16'h0010, 5'b00000);
        chk("jcond_uc_pc", pc, 16'h0010);
        chk("jcond_uc_taken", {15'b0, taken}, 16'h0001);
        chk("jcond_uc_link_we", {15'b0, link_we}, 16'h0000);
        step(2'b01, 4'h0, 8'hFC, 16'h0000, 5'b01000);
        chk("bcond_eq_t_pc", pc, 16'h000C);
        chk("bcond_eq_t_taken", {15'b0, taken}, 16'h0001);
        idle();
        chk("bcond_taken_drop", {15'b0, taken}, 16'h0000);

        // Bcond EQ not taken
        step(2'b10, 4'hE, 8'h00, 16'h0010, 5'b00000);
        step(2'b01, 4'h0, 8'hFC, 16'h0000, 5'b00000);
        chk("bcond_eq_nt_pc", pc, 16'h0011);
        chk("bcond_eq_nt_taken", {15'b0, taken}, 16'h0000);

        // JAL then Jcond never
        step(2'b10, 4'hE, 8'h00, 16'h0020, 5'b00000);
        step(2'b11, 4'hF, 8'h00, 16'h0100, 5'b00000);
        chk("jal_pc", pc, 16'h0100);
        chk("jal_link_data", link_data, 16'h0021);
        chk("jal_link_we", {15'b0, link_we}, 16'h0001);
        chk("jal_taken", {15'b0, taken}, 16'h0001);
        step(2'b10, 4'hF, 8'h00, 16'h0200, 5'b11111);
        chk("jcond_nv_pc", pc, 16'h0101);
        chk("jal_link_we_drop", {15'b0, link_we}, 16'h0000);
        chk("jal_link_data_hold", link_data, 16'h0021);
        chk("jcond_nv_taken", {15'b0, taken}, 16'h0000);

        // Compound conditions: LO taken with L=0,Z=0; GE not taken with N=0,Z=0
        step(2'b10, 4'hA, 8'h00, 16'h0300, 5'b00000);
        chk("jcond_lo_pc", pc, 16'h0300);
        step(2'b10, 4'hD, 8'h00, 16'h0400, 5'b00000);
        chk("jcond_ge_nt_pc", pc, 16'h0301);
        step(2'b01, 4'h6, 8'h10, 16'h0000, 5'b10000);
        chk("bcond_gt_pc", pc, 16'h0311);

        // Wrap at the top of the address space and below zero
        step(2'b10, 4'hE, 8'h00, 16'hFFFF, 5'b00000);
        chk("wrap_pc_plus1", pc_plus1, 16'h0000);
        step(2'b00, 4'h0, 8'h00, 16'h0000, 5'b00000);
        chk("wrap_seq_pc", pc, 16'h0000);
        step(2'b10, 4'hE, 8'h00, 16'h0002, 5'b00000);
        step(2'b01, 4'hE, 8'h80, 16'h0000, 5'b00000);
        chk("wrap_bcond_pc", pc, 16'hFF82);

        // Idle cycles hold state
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("idle_pc", pc, 16'hFF82);
            chk("idle_link_data", link_data, 16'h0021);
            chk("idle_link_we", {15'b0, link_we}, 16'h0000);
            chk("idle_taken", {15'b0, taken}, 16'h0000);
        end

        // Reset asserted while a JAL is pending
        @(negedge clk);
        pc_en = 1'b1; br_type = 2'b11; cond = 4'h0; tgt_reg = 16'h0500;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        pc_en = 1'b0;
        chk("rst_jal_pc", pc, 16'h0000);
        chk("rst_jal_link_we", {15'b0, link_we}, 16'h0000);
        chk("rst_jal_link_data", link_data, 16'h0000);
        chk("rst_jal_taken", {15'b0, taken}, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        idle();
        chk("rst_jal_after_link_we", {15'b0, link_we}, 16'h0000);
        chk("rst_jal_after_pc", pc, 16'h0000);

        // Branch to self
        step(2'b10, 4'hE, 8'h00, 16'h0030, 5'b00000);
        step(2'b01, 4'hE, 8'h00, 16'h0000, 5'b00000);
        chk("self_pc", pc, 16'h0030);
        chk("self_taken", {15'b0, taken}, 16'h0001);
`ifdef PC_HALT_DETECT_EN
        chk("self_halted", {15'b0, halted}, 16'h0001);
`else
        chk("self_halted", {15'b0, halted}, 16'h0000);
`endif
        step(2'b01, 4'hE, 8'h00, 16'h0000, 5'b00000);
        chk("self_again_pc", pc, 16'h0030);
        step(2'b00, 4'h0, 8'h00, 16'h0000, 5'b00000);
`ifdef PC_HALT_DETECT_EN
        chk("self_seq_pc", pc, 16'h0030);
        chk("self_seq_halted", {15'b0, halted}, 16'h0001);
`else
        chk("self_seq_pc", pc, 16'h0031);
        chk("self_seq_halted", {15'b0, halted}, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
